// File: rtl/overflow_exception_unit_pkg.sv
// Shared definitions for the overflow exception unit: FSM encoding, CP0 selects,
// Status/Cause bit positions and exception codes.
package overflow_exception_unit_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FLUSH    = 3'd1,
      ST_REDIRECT = 3'd2,
      ST_HANDLER  = 3'd3,
      ST_RETURN   = 3'd4
   } exc_state_t;

   localparam logic [1:0] SEL_EPC    = 2'd0;
   localparam logic [1:0] SEL_CAUSE  = 2'd1;
   localparam logic [1:0] SEL_STATUS = 2'd2;
   localparam logic [1:0] SEL_OVFCNT = 2'd3;

   localparam int STATUS_OVE_BIT = 0;
   localparam int STATUS_EXL_BIT = 1;
   localparam int CAUSE_EXC_LSB  = 2;
   localparam int CAUSE_EXC_MSB  = 6;
   localparam int CAUSE_LOST_BIT = 31;

   localparam logic [4:0] EXC_CODE_NONE = 5'd0;
   localparam logic [4:0] EXC_CODE_OV   = 5'd12;

   function automatic logic [31:0] make_cause(input logic lost, input logic [4:0] exc_code);
      logic [31:0] c;
      c = '0;
      c[CAUSE_LOST_BIT] = lost;
      c[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = exc_code;
      return c;
   endfunction

endpackage

// File: rtl/overflow_exception_unit_if.sv
// Pipeline-facing bundle of the overflow exception unit; master is the pipeline,
// slave is the exception unit.
interface overflow_exception_unit_if;
   logic        overflow_in;
   logic        instr_valid;
   logic [31:0] pc_ex;
   logic        eret;
   logic [1:0]  cp0_rsel;
   logic [31:0] cp0_rdata;
   logic        cp0_we;
   logic [1:0]  cp0_wsel;
   logic [31:0] cp0_wdata;
   logic        flush;
   logic        pc_redirect;
   logic [31:0] pc_target;
   logic        in_handler;

   modport master (
      output overflow_in, instr_valid, pc_ex, eret,
      output cp0_rsel, cp0_we, cp0_wsel, cp0_wdata,
      input  cp0_rdata, flush, pc_redirect, pc_target, in_handler
   );

   modport slave (
      input  overflow_in, instr_valid, pc_ex, eret,
      input  cp0_rsel, cp0_we, cp0_wsel, cp0_wdata,
      output cp0_rdata, flush, pc_redirect, pc_target, in_handler
   );
endinterface

// File: rtl/overflow_exception_unit_ovf_event_counter.sv
// 16-bit saturating event counter backing the OvfCount CP0 register.
module ovf_event_counter (
   input  logic        clock,
   input  logic        reset,
   input  logic        inc,
   output logic [15:0] count
);

   logic [15:0] count_q;
   logic [15:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != 16'hFFFF)) begin
         count_d = count_q + 16'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/overflow_exception_unit.sv
// Minimal CP0 servicing ALU overflow: capture EPC/Cause, flush, vector, eret.
// Optional OvfCount register built when OVF_COUNTER_EN is defined.
module overflow_exception_unit
   import overflow_exception_unit_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180,
   parameter logic [4:0]  OVF_EXC_CODE = EXC_CODE_OV,
   parameter int          FLUSH_CYCLES = 2   // legal 1..7
) (
   input  logic                      clock,
   input  logic                      reset,
   overflow_exception_unit_if.slave  bus
);

   localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

   exc_state_t  state_q, state_d;
   logic [2:0]  flush_cnt_q, flush_cnt_d;
   logic [31:0] epc_q, epc_d;
   logic [4:0]  exc_code_q, exc_code_d;
   logic        lost_q, lost_d;
   logic        ove_q, ove_d;
   logic        exl_q, exl_d;

   logic        ovf_seen;
   logic        trigger;
   logic        lost_event;
   logic        status_wr_ok;
   logic [15:0] ovf_count;

   // Masked overflows (OVE=0) are invisible: no trap, no LOST, no count.
   assign ovf_seen     = bus.overflow_in & bus.instr_valid & ove_q;
   assign trigger      = ovf_seen & ~exl_q & (state_q == ST_IDLE);
   assign lost_event   = ovf_seen & (state_q != ST_IDLE);
   assign status_wr_ok = (state_q == ST_IDLE) || (state_q == ST_HANDLER);

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      epc_d       = epc_q;
      exc_code_d  = exc_code_q;
      lost_d      = lost_q;
      ove_d       = ove_q;
      exl_d       = exl_q;

      if (bus.cp0_we && (bus.cp0_wsel == SEL_EPC)) begin
         epc_d = bus.cp0_wdata;
      end
      if (bus.cp0_we && (bus.cp0_wsel == SEL_STATUS) && status_wr_ok) begin
         ove_d = bus.cp0_wdata[STATUS_OVE_BIT];
         exl_d = bus.cp0_wdata[STATUS_EXL_BIT];
      end
      if (lost_event) begin
         lost_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (trigger) begin
               // Capture overrides any same-cycle EPC/Status write.
               epc_d       = bus.pc_ex;
               exc_code_d  = OVF_EXC_CODE;
               exl_d       = 1'b1;
               flush_cnt_d = '0;
               state_d     = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (flush_cnt_q == FLUSH_LAST) begin
               state_d = ST_REDIRECT;
            end else begin
               flush_cnt_d = flush_cnt_q + 3'd1;
            end
         end
         ST_REDIRECT: begin
            state_d = ST_HANDLER;
         end
         ST_HANDLER: begin
            if (bus.eret) begin
               state_d = ST_RETURN;
            end
         end
         ST_RETURN: begin
            exl_d   = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         flush_cnt_q <= '0;
         epc_q       <= '0;
         exc_code_q  <= EXC_CODE_NONE;
         lost_q      <= 1'b0;
         ove_q       <= 1'b1;
         exl_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         epc_q       <= epc_d;
         exc_code_q  <= exc_code_d;
         lost_q      <= lost_d;
         ove_q       <= ove_d;
         exl_q       <= exl_d;
      end
   end

`ifdef OVF_COUNTER_EN
   logic count_inc;
   assign count_inc = trigger | lost_event;

   ovf_event_counter u_ovf_event_counter (
      .clock (clock),
      .reset (reset),
      .inc   (count_inc),
      .count (ovf_count)
   );
`else
   assign ovf_count = 16'h0000;
`endif

   always_comb begin
      bus.flush       = 1'b0;
      bus.pc_redirect = 1'b0;
      bus.pc_target   = '0;
      case (state_q)
         ST_FLUSH: begin
            bus.flush = 1'b1;
         end
         ST_REDIRECT: begin
            bus.flush       = 1'b1;
            bus.pc_redirect = 1'b1;
            bus.pc_target   = EXC_VECTOR;
         end
         ST_RETURN: begin
            bus.flush       = 1'b1;
            bus.pc_redirect = 1'b1;
            bus.pc_target   = epc_q + 32'd4;
         end
         default: begin
            bus.flush = 1'b0;
         end
      endcase
   end

   assign bus.in_handler = exl_q;

   // Read port is forced to zero while reset is held so every output reads 0.
   always_comb begin
      bus.cp0_rdata = '0;
      if (!reset) begin
         case (bus.cp0_rsel)
            SEL_EPC:    bus.cp0_rdata = epc_q;
            SEL_CAUSE:  bus.cp0_rdata = make_cause(lost_q, exc_code_q);
            SEL_STATUS: bus.cp0_rdata = {30'd0, exl_q, ove_q};
            SEL_OVFCNT: bus.cp0_rdata = {16'd0, ovf_count};
            default:    bus.cp0_rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_overflow_exception_unit.sv
// Directed bench for overflow_exception_unit: entry, return, nesting, masking,
// CP0 writes with EPC wrap, and asynchronous reset during FLUSH.
module tb_overflow_exception_unit;
   import overflow_exception_unit_pkg::*;

   logic clock;
   logic reset;
   int   errors;
   int   checks;
   logic [31:0] rd;
   logic [31:0] exp_cnt;

   overflow_exception_unit_if bus();

   overflow_exception_unit dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic cp0_read(input logic [1:0] sel, output logic [31:0] data);
      bus.cp0_rsel = sel;
      #1;
      data = bus.cp0_rdata;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   task automatic clear_inputs();
      bus.overflow_in = 1'b0;
      bus.instr_valid = 1'b0;
      bus.pc_ex       = '0;
      bus.eret        = 1'b0;
      bus.cp0_rsel    = SEL_EPC;
      bus.cp0_we      = 1'b0;
      bus.cp0_wsel    = SEL_EPC;
      bus.cp0_wdata   = '0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({bus.flush, bus.pc_redirect, bus.in_handler} !== 3'b000) begin
         $display("FAIL reset_outputs: got flush/redir/inh=%b want 000", {bus.flush, bus.pc_redirect, bus.in_handler});
         errors++;
      end
      cp0_read(SEL_STATUS, rd);
      checks++;
      if (rd !== 32'h1) begin $display("FAIL reset_status: got %h want 00000001", rd); errors++; end
      cp0_read(SEL_CAUSE, rd);
      checks++;
      if (rd !== 32'h0) begin $display("FAIL reset_cause: got %h want 00000000", rd); errors++; end
      cp0_read(SEL_OVFCNT, rd);
      checks++;
      if (rd !== 32'h0) begin $display("FAIL reset_ovfcnt: got %h want 00000000", rd); errors++; end
      bus.eret = 1'b1;
      step();
      bus.eret = 1'b0;
      checks++;
      if (bus.pc_redirect !== 1'b0) begin $display("FAIL eret_in_idle: got redirect=%b want 0", bus.pc_redirect); errors++; end
      $display("test_reset done");
   endtask

   task automatic test_basic_entry();
      bus.overflow_in = 1'b1; bus.instr_valid = 1'b1; bus.pc_ex = 32'h0040_0020;
      step();
      bus.overflow_in = 1'b0; bus.instr_valid = 1'b0;
      checks++;
      if ({bus.flush, bus.pc_redirect, bus.in_handler} !== 3'b101) begin
         $display("FAIL entry_flush1: got flush/redir/inh=%b want 101", {bus.flush, bus.pc_redirect, bus.in_handler}); errors++;
      end
      step();
      checks++;
      if ({bus.flush, bus.pc_redirect} !== 2'b10) begin
         $display("FAIL entry_flush2: got flush/redir=%b want 10", {bus.flush, bus.pc_redirect}); errors++;
      end
      step();
      checks++;
      if ({bus.flush, bus.pc_redirect} !== 2'b11 || bus.pc_target !== 32'h0000_0180) begin
         $display("FAIL entry_redirect: got flush/redir=%b target=%h want 11 00000180", {bus.flush, bus.pc_redirect}, bus.pc_target); errors++;
      end
      step();
      checks++;
      if ({bus.flush, bus.pc_redirect, bus.in_handler} !== 3'b001) begin
         $display("FAIL entry_handler: got flush/redir/inh=%b want 001", {bus.flush, bus.pc_redirect, bus.in_handler}); errors++;
      end
      cp0_read(SEL_EPC, rd);
      checks++;
      if (rd !== 32'h0040_0020) begin $display("FAIL entry_epc: got %h want 00400020", rd); errors++; end
      cp0_read(SEL_CAUSE, rd);
      checks++;
      if (rd !== 32'h0000_0030) begin $display("FAIL entry_cause: got %h want 00000030", rd); errors++; end
      $display("test_basic_entry done");
   endtask

   task automatic test_return();
      bus.eret = 1'b1;
      step();
      bus.eret = 1'b0;
      checks++;
      if ({bus.flush, bus.pc_redirect, bus.in_handler} !== 3'b111 || bus.pc_target !== 32'h0040_0024) begin
         $display("FAIL return_redirect: got flush/redir/inh=%b target=%h want 111 00400024",
                  {bus.flush, bus.pc_redirect, bus.in_handler}, bus.pc_target); errors++;
      end
      step();
      checks++;
      if ({bus.flush, bus.pc_redirect, bus.in_handler} !== 3'b000) begin
         $display("FAIL return_idle: got flush/redir/inh=%b want 000", {bus.flush, bus.pc_redirect, bus.in_handler}); errors++;
      end
      $display("test_return done");
   endtask

   task automatic test_nested();
      do_reset();
      bus.overflow_in = 1'b1; bus.instr_valid = 1'b1; bus.pc_ex = 32'h0040_0100;
      step();
      bus.overflow_in = 1'b0; bus.instr_valid = 1'b0;
      repeat (3) step();
      // overflow while in HANDLER
      bus.overflow_in = 1'b1; bus.instr_valid = 1'b1; bus.pc_ex = 32'hDEAD_0000;
      step();
      bus.overflow_in = 1'b0; bus.instr_valid = 1'b0;
      checks++;
      if ({bus.flush, bus.pc_redirect, bus.in_handler} !== 3'b001) begin
         $display("FAIL nested_no_reentry: got flush/redir/inh=%b want 001", {bus.flush, bus.pc_redirect, bus.in_handler}); errors++;
      end
      cp0_read(SEL_CAUSE, rd);
      checks++;
      if (rd !== 32'h8000_0030) begin $display("FAIL nested_lost: got %h want 80000030", rd); errors++; end
      bus.overflow_in = 1'b1; bus.instr_valid = 1'b1; bus.eret = 1'b1;
      step();
      bus.overflow_in = 1'b0; bus.instr_valid = 1'b0; bus.eret = 1'b0;
      checks++;
      if (bus.pc_redirect !== 1'b1 || bus.pc_target !== 32'h0040_0104) begin
         $display("FAIL nested_return: got redir=%b target=%h want 1 00400104", bus.pc_redirect, bus.pc_target); errors++;
      end
      step();
      step();
      checks++;
      if ({bus.flush, bus.pc_redirect, bus.in_handler} !== 3'b000) begin
         $display("FAIL nested_single_return: got flush/redir/inh=%b want 000", {bus.flush, bus.pc_redirect, bus.in_handler}); errors++;
      end
      cp0_read(SEL_EPC, rd);
      checks++;
      if (rd !== 32'h0040_0100) begin $display("FAIL nested_epc: got %h want 00400100", rd); errors++; end
      cp0_read(SEL_OVFCNT, rd);
      checks++;
      if (rd !== exp_cnt) begin $display("FAIL nested_ovfcnt: got %h want %h", rd, exp_cnt); errors++; end
      $display("test_nested done");
   endtask

   task automatic test_masking();
      bus.cp0_we = 1'b1; bus.cp0_wsel = SEL_STATUS; bus.cp0_wdata = 32'h0;
      step();
      bus.cp0_we = 1'b0;
      cp0_read(SEL_STATUS, rd);
      checks++;
      if (rd !== 32'h0) begin $display("FAIL mask_status: got %h want 00000000", rd); errors++; end
      bus.overflow_in = 1'b1; bus.instr_valid = 1'b1; bus.pc_ex = 32'h0050_0000;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({bus.flush, bus.pc_redirect} !== 2'b00) begin
            $display("FAIL mask_no_flush: cycle %0d got flush/redir=%b want 00", i, {bus.flush, bus.pc_redirect}); errors++;
         end
      end
      bus.overflow_in = 1'b0; bus.instr_valid = 1'b0;
      cp0_read(SEL_CAUSE, rd);
      checks++;
      if (rd !== 32'h8000_0030) begin $display("FAIL mask_cause: got %h want 80000030", rd); errors++; end
      cp0_read(SEL_OVFCNT, rd);
      checks++;
      if (rd !== exp_cnt) begin $display("FAIL mask_ovfcnt: got %h want %h", rd, exp_cnt); errors++; end
      bus.cp0_we = 1'b1; bus.cp0_wsel = SEL_STATUS; bus.cp0_wdata = 32'h1;
      step();
      bus.cp0_we = 1'b0;
      cp0_read(SEL_STATUS, rd);
      checks++;
      if (rd !== 32'h1) begin $display("FAIL mask_restore: got %h want 00000001", rd); errors++; end
      $display("test_masking done");
   endtask

   task automatic test_cp0_writes();
      bus.overflow_in = 1'b1; bus.instr_valid = 1'b1; bus.pc_ex = 32'h0000_1000;
      bus.cp0_we = 1'b1; bus.cp0_wsel = SEL_EPC; bus.cp0_wdata = 32'h1234_5678;
      step();
      bus.overflow_in = 1'b0; bus.instr_valid = 1'b0; bus.cp0_we = 1'b0;
      cp0_read(SEL_EPC, rd);
      checks++;
      if (rd !== 32'h0000_1000) begin $display("FAIL wr_epc_override: got %h want 00001000", rd); errors++; end
      bus.cp0_we = 1'b1; bus.cp0_wsel = SEL_STATUS; bus.cp0_wdata = 32'h0;
      step();
      bus.cp0_we = 1'b0;
      cp0_read(SEL_STATUS, rd);
      checks++;
      if (rd !== 32'h3) begin $display("FAIL wr_status_in_flush: got %h want 00000003", rd); errors++; end
      step();
      step();
      bus.cp0_we = 1'b1; bus.cp0_wsel = SEL_EPC; bus.cp0_wdata = 32'hFFFF_FFFC;
      step();
      bus.cp0_we = 1'b0;
      cp0_read(SEL_EPC, rd);
      checks++;
      if (rd !== 32'hFFFF_FFFC) begin $display("FAIL wr_epc: got %h want fffffffc", rd); errors++; end
      bus.eret = 1'b1;
      step();
      bus.eret = 1'b0;
      checks++;
      if (bus.pc_redirect !== 1'b1 || bus.pc_target !== 32'h0000_0000) begin
         $display("FAIL wrap_target: got redir=%b target=%h want 1 00000000", bus.pc_redirect, bus.pc_target); errors++;
      end
      step();
      checks++;
      if (bus.in_handler !== 1'b0) begin $display("FAIL wrap_exit: got in_handler=%b want 0", bus.in_handler); errors++; end
      $display("test_cp0_writes done");
   endtask

   task automatic test_reset_mid_flush();
      bus.overflow_in = 1'b1; bus.instr_valid = 1'b1; bus.pc_ex = 32'h0040_0020;
      step();
      bus.overflow_in = 1'b0; bus.instr_valid = 1'b0;
      checks++;
      if (bus.flush !== 1'b1) begin $display("FAIL rst_pre_flush: got flush=%b want 1", bus.flush); errors++; end
      bus.cp0_rsel = SEL_STATUS;
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({bus.flush, bus.pc_redirect, bus.in_handler} !== 3'b000 || bus.pc_target !== 32'h0 || bus.cp0_rdata !== 32'h0) begin
         $display("FAIL rst_async_outputs: got flush/redir/inh=%b target=%h rdata=%h want 000 0 0",
                  {bus.flush, bus.pc_redirect, bus.in_handler}, bus.pc_target, bus.cp0_rdata); errors++;
      end
      step();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if ({bus.flush, bus.pc_redirect} !== 2'b00) begin
            $display("FAIL rst_no_redirect: cycle %0d got flush/redir=%b want 00", i, {bus.flush, bus.pc_redirect}); errors++;
         end
      end
      cp0_read(SEL_STATUS, rd);
      checks++;
      if (rd !== 32'h1) begin $display("FAIL rst_status: got %h want 00000001", rd); errors++; end
      cp0_read(SEL_EPC, rd);
      checks++;
      if (rd !== 32'h0) begin $display("FAIL rst_epc: got %h want 00000000", rd); errors++; end
      $display("test_reset_mid_flush done");
   endtask

   initial begin
      errors = 0;
      checks = 0;
`ifdef OVF_COUNTER_EN
      exp_cnt = 32'd3;
`else
      exp_cnt = 32'd0;
`endif
      reset = 1'b1;
      clear_inputs();
      test_reset();
      test_basic_entry();
      test_return();
      test_nested();
      test_masking();
      test_cp0_writes();
      test_reset_mid_flush();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/overflow_exception_unit.md
# overflow_exception_unit

Consumer end of the ALU overflow path. Samples the ALU overflow flag for each valid EX-stage instruction, records the faulting PC and cause, flushes the pipeline, redirects fetch to the exception vector, and restores flow on `eret`. Sits beside the EX stage as a minimal coprocessor-0. Its state is readable through an `mfc0`-style port and partly writable through an `mtc0`-style port.

## Interface
Parameters:
- `EXC_VECTOR`, default 32'h0000_0180: handler entry address.
- `OVF_EXC_CODE`, default 5'd12: value written to the Cause ExcCode field, which is Cause[6:2].
- `FLUSH_CYCLES`, default 2, legal range 1..7: number of cycles `flush` is held per entry.

Ports (reset is asynchronous and active-high; the clock is `clock` and the reset is `reset`):
- `clock` in 1: rising-edge clock.
- `reset` in 1: async active-high reset.
- `overflow_in` in 1: overflow flag from the ALU overflow detector.
- `instr_valid` in 1: EX-stage instruction is valid.
- `pc_ex` in 32: PC of the EX-stage instruction.
- `eret` in 1: handler issues return-from-exception.
- `cp0_rsel` in 2: read select. 0=EPC, 1=Cause, 2=Status, 3=OvfCount.
- `cp0_rdata` out 32: combinational read data for `cp0_rsel`.
- `cp0_we` in 1: write strobe.
- `cp0_wsel` in 2: write select. Only 0 (EPC) and 2 (Status) are writable; other selects are ignored.
- `cp0_wdata` in 32: write data.
- `flush` out 1: kill IF/ID/EX contents.
- `pc_redirect` out 1: the PC must load `pc_target` this cycle.
- `pc_target` out 32: redirect address.
- `in_handler` out 1: Status.EXL.

## Operation
Registers and reset values:
- EPC: 0.
- Cause: 0. Cause[6:2] is ExcCode. Cause[31] is LOST, a sticky flag.
- Status: 32'h1. Status[0] is OVE (trap enable). Status[1] is EXL.
- OvfCount: 0.

All outputs are 0 in reset.

Trigger: a trigger occurs when `overflow_in & instr_valid & OVE & ~EXL` is true in IDLE.

FSM (Moore outputs decoded from the state register):
- **IDLE**
  - On trigger: EPC <= `pc_ex`, ExcCode <= `OVF_EXC_CODE`, EXL <= 1, and go to FLUSH.
  - `eret` in IDLE is ignored.
- **FLUSH**
  - `flush` = 1.
  - A 3-bit counter runs `FLUSH_CYCLES` cycles, then the FSM goes to REDIRECT.
- **REDIRECT**
  - `pc_redirect` = 1, `pc_target` = `EXC_VECTOR`.
  - `flush` = 1.
  - Goes to HANDLER after 1 cycle.
- **HANDLER**
  - Waits for `eret`.
  - On `eret`: go to RETURN.
- **RETURN**
  - `pc_redirect` = 1, `pc_target` = EPC + 4 (the faulting instruction is skipped; addition wraps modulo 2^32).
  - `flush` = 1.
  - EXL <= 0, then go to IDLE after 1 cycle.

Boundary rules:
- **Overflow outside IDLE:** `overflow_in & instr_valid` in any state other than IDLE sets LOST. No other effect.
- **Overflow and `eret` together in HANDLER:** `eret` wins and LOST is set.
- **Masked overflow:** overflow with OVE=0 is ignored entirely. LOST is not set and the counter does not count.
- **CP0 writes:**
  - `cp0_we` to EPC takes effect at the next edge. The EPC capture on a trigger overrides a same-cycle write.
  - `cp0_we` to Status writes only bits [1:0]. It is ignored outside HANDLER/IDLE.
  - Writes to Cause are ignored, so LOST clears only on reset.
- **Reset mid-sequence:** the FSM returns to IDLE, all registers take their reset values, and no redirect is issued.

## Timing
- Trigger sampled at edge N:
  - `flush` high from cycle N+1 through N+`FLUSH_CYCLES`+1, inclusive of the REDIRECT cycle.
  - `pc_redirect` high for exactly cycle N+`FLUSH_CYCLES`+1.
- `eret` sampled at edge M in HANDLER: `pc_redirect` and `flush` are high for cycle M+1, and `in_handler` falls at edge M+1.
- Minimum spacing between two serviced overflows: `FLUSH_CYCLES`+4 cycles.
- `cp0_rdata` is combinational with zero latency. It reflects register state after the last edge.

## Configuration
- `OVF_COUNTER_EN` defined:
  - OvfCount is a 16-bit saturating counter, zero-extended on read.
  - It increments on every trigger and on every LOST event.
  - It holds at 16'hFFFF.
- `OVF_COUNTER_EN` undefined: no counter logic is built, and `cp0_rsel`=3 reads 0.

## Structure
- Shared package holds:
  - the FSM state encoding (IDLE, FLUSH, REDIRECT, HANDLER, RETURN);
  - the CP0 select constants (SEL_EPC, SEL_CAUSE, SEL_STATUS, SEL_OVFCNT);
  - the Status/Cause bit-position constants;
  - the ExcCode constants.
- One sub-module, `ovf_event_counter`: the saturating counter, instantiated only under `OVF_COUNTER_EN`.

## Test plan
- **Basic entry:** reset, then `overflow_in`=1, `instr_valid`=1, `pc_ex`=32'h0040_0020. Expect `flush` high 2 cycles, then `pc_redirect`=1 with `pc_target`=32'h0000_0180. Expect EPC=32'h0040_0020, Cause=32'h0000_0030, `in_handler`=1.
- **Return:** from HANDLER, pulse `eret`. Expect next cycle `pc_redirect`=1, `pc_target`=32'h0040_0024, `flush`=1, then IDLE with `in_handler`=0.
- **Nested and simultaneous:** overflow during HANDLER, then overflow together with `eret`. Expect EPC unchanged, Cause[31]=1, single return to EPC+4. With the counter built, OvfCount=3.
- **Masking:** write Status=0 via `cp0_we`, then apply overflow. Expect no flush, no redirect, Cause and OvfCount unchanged.
- **Wrap-around:** with EPC written to 32'hFFFF_FFFC, `eret` redirects to 32'h0000_0000.
- **Async reset mid-FLUSH:** expect all outputs 0 immediately, no redirect afterwards, Status=1.
